// File: rtl/fault_supervisor_if.sv
// Signal bundle between the A2D/PWM/auth side and the fault supervisor.
// Master drives the raw fault/battery/control inputs; slave returns enable and status.
interface fault_supervisor_if;
   logic        pwm_synch;
   logic        OVR_I_lft;
   logic        OVR_I_rght;
   logic [11:0] batt;
   logic        batt_vld;
   logic        pwr_up;
   logic        clr_fault;
   logic        mtr_en;
   logic        batt_low;
   logic        OVR_I_shtdwn;
   logic [1:0]  fault_code;

   modport master (
      output pwm_synch, OVR_I_lft, OVR_I_rght, batt, batt_vld, pwr_up, clr_fault,
      input  mtr_en, batt_low, OVR_I_shtdwn, fault_code
   );

   modport slave (
      input  pwm_synch, OVR_I_lft, OVR_I_rght, batt, batt_vld, pwr_up, clr_fault,
      output mtr_en, batt_low, OVR_I_shtdwn, fault_code
   );
endinterface

// File: rtl/fault_supervisor.sv
// Over-current qualification against PWM blanking, hysteretic low-battery flag and the
// shutdown / cool-down / recovery sequencer that gates motor enable.
module fault_supervisor #(
   parameter int unsigned OVR_I_LIMIT = 8,
   parameter int unsigned BLANK       = 40,
   parameter int unsigned COOL_CYCLES = 1000000,
   parameter logic [11:0] BATT_THRESH = 12'h800,
   parameter logic [11:0] BATT_HYST   = 12'h080
) (
   input logic               clk,
   input logic               rst,
   fault_supervisor_if.slave bus
);

   localparam int unsigned    BW       = $clog2(BLANK + 2);
   localparam logic [BW-1:0]  BlankMax = BW'(BLANK);
   localparam logic [7:0]     OcMax    = 8'(OVR_I_LIMIT);
   localparam logic [23:0]    CoolLast = 24'(COOL_CYCLES - 1);
   localparam logic [12:0]    BattClr  = {1'b0, BATT_THRESH} + {1'b0, BATT_HYST};

   typedef enum logic [2:0] {StIdle, StRun, StWarn, StShtdwn, StCool} state_e;

   state_e          state_q, state_d;
   logic [BW-1:0]   blank_cnt_q, blank_cnt_d;
   logic            per_flag_q, per_flag_d;
   logic [7:0]      oc_cnt_q, oc_cnt_d;
   logic [23:0]     cool_cnt_q, cool_cnt_d;
   logic            batt_low_q, batt_low_d;
   logic            mtr_en_q, mtr_en_d;
   logic            shtdwn_q, shtdwn_d;
   logic [1:0]      fault_code_q, fault_code_d;

   logic sample;
   logic period_bad;
   logic oc_trip;

   // A sample taken on the pwm_synch clock still belongs to the period that is ending.
   assign sample     = (blank_cnt_q == BlankMax) & (bus.OVR_I_lft | bus.OVR_I_rght);
   assign period_bad = per_flag_q | sample;

   always_comb begin
      blank_cnt_d = blank_cnt_q;
      per_flag_d  = per_flag_q;
      oc_cnt_d    = oc_cnt_q;
      batt_low_d  = batt_low_q;

      if (bus.batt_vld) begin
         if (bus.batt < BATT_THRESH) begin
            batt_low_d = 1'b1;
         end else if ({1'b0, bus.batt} >= BattClr) begin
            batt_low_d = 1'b0;
         end
      end

      if (!bus.pwr_up) begin
         blank_cnt_d = '0;
         per_flag_d  = 1'b0;
         oc_cnt_d    = '0;
      end else if (bus.pwm_synch) begin
         blank_cnt_d = '0;
         per_flag_d  = 1'b0;
         if (period_bad) begin
            oc_cnt_d = (oc_cnt_q == OcMax) ? oc_cnt_q : oc_cnt_q + 8'd1;
         end else begin
            oc_cnt_d = '0;
         end
      end else begin
         if (blank_cnt_q != BlankMax) begin
            blank_cnt_d = blank_cnt_q + BW'(1);
         end
         if (sample) begin
            per_flag_d = 1'b1;
         end
      end
   end

   // Trip on the count being loaded so shutdown lands one clock after the final pwm_synch.
   assign oc_trip = (oc_cnt_d == OcMax);

   always_comb begin
      state_d    = state_q;
      cool_cnt_d = cool_cnt_q;

      if (!bus.pwr_up) begin
         state_d    = StIdle;
         cool_cnt_d = '0;
      end else begin
         unique case (state_q)
            StIdle: state_d = StRun;
            StRun: begin
               if (oc_trip) begin
                  state_d = StShtdwn;
               end else if (batt_low_q) begin
                  state_d = StWarn;
               end
            end
            StWarn: begin
               if (oc_trip) begin
                  state_d = StShtdwn;
               end else if (!batt_low_q) begin
                  state_d = StRun;
               end
            end
            StShtdwn: begin
               cool_cnt_d = '0;
               if (bus.pwm_synch && !period_bad) begin
                  state_d = StCool;
               end
            end
            StCool: begin
               if (bus.pwm_synch && period_bad) begin
                  state_d    = StShtdwn;
                  cool_cnt_d = '0;
               end else if ((cool_cnt_q == CoolLast) || bus.clr_fault) begin
                  state_d = batt_low_q ? StWarn : StRun;
               end else begin
                  cool_cnt_d = cool_cnt_q + 24'd1;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      mtr_en_d     = (state_d == StRun) || (state_d == StWarn);
      shtdwn_d     = (state_d == StShtdwn) || (state_d == StCool);
      fault_code_d = {shtdwn_d, batt_low_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         blank_cnt_q  <= '0;
         per_flag_q   <= 1'b0;
         oc_cnt_q     <= '0;
         cool_cnt_q   <= '0;
         batt_low_q   <= 1'b0;
         mtr_en_q     <= 1'b0;
         shtdwn_q     <= 1'b0;
         fault_code_q <= 2'b00;
      end else begin
         state_q      <= state_d;
         blank_cnt_q  <= blank_cnt_d;
         per_flag_q   <= per_flag_d;
         oc_cnt_q     <= oc_cnt_d;
         cool_cnt_q   <= cool_cnt_d;
         batt_low_q   <= batt_low_d;
         mtr_en_q     <= mtr_en_d;
         shtdwn_q     <= shtdwn_d;
         fault_code_q <= fault_code_d;
      end
   end

   assign bus.mtr_en       = mtr_en_q;
   assign bus.batt_low     = batt_low_q;
   assign bus.OVR_I_shtdwn = shtdwn_q;
   assign bus.fault_code   = fault_code_q;

endmodule

// File: tb/tb_fault_supervisor.sv
// Scoreboard bench for fault_supervisor: a behavioural model queues expected outputs per
// clock, a negedge monitor compares them, and directed checks pin the key latencies.
module tb_fault_supervisor;

   localparam int          LIM   = 8;
   localparam int          BLK   = 40;
   localparam int          COOLN = 1000;
   localparam int          PER   = 64;
   localparam logic [11:0] THR   = 12'h800;
   localparam logic [11:0] HYS   = 12'h080;

   localparam int ModeOff      = 0;
   localparam int ModeDrive    = 1;
   localparam int ModeDriveLow = 2;
   localparam int ModeTripped  = 3;
   localparam int ModeCooling  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fault_supervisor_if ifc ();

   fault_supervisor #(
      .OVR_I_LIMIT (LIM),
      .BLANK       (BLK),
      .COOL_CYCLES (COOLN),
      .BATT_THRESH (THR),
      .BATT_HYST   (HYS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ph       = 0;
   bit rnd      = 1'b0;

   logic [4:0] exp_q[$];

   // Model: mode, clocks since last period start (saturating), fault seen this period,
   // run of consecutive faulted periods, clocks spent cooling, low-battery flag.
   int m_mode   = ModeOff;
   int m_since  = 0;
   bit m_pfault = 1'b0;
   int m_streak = 0;
   int m_cool   = 0;
   bit m_low    = 1'b0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit ovr, sample, bad, old_low, trip, mtr, shut;
      if (rst) begin
         m_mode = ModeOff; m_since = 0; m_pfault = 0; m_streak = 0; m_cool = 0; m_low = 0;
      end else begin
         ovr     = ifc.OVR_I_lft || ifc.OVR_I_rght;
         sample  = ovr && (m_since >= BLK);
         bad     = m_pfault || sample;
         old_low = m_low;
         if (ifc.batt_vld) begin
            if (int'(ifc.batt) < int'(THR)) m_low = 1'b1;
            else if (int'(ifc.batt) >= int'(THR) + int'(HYS)) m_low = 1'b0;
         end
         if (!ifc.pwr_up) begin
            m_mode = ModeOff; m_since = 0; m_pfault = 0; m_streak = 0; m_cool = 0;
         end else begin
            if (ifc.pwm_synch) begin
               m_streak = bad ? ((m_streak + 1 > LIM) ? LIM : m_streak + 1) : 0;
               m_pfault = 1'b0;
               m_since  = 0;
            end else begin
               if (sample) m_pfault = 1'b1;
               if (m_since < BLK) m_since++;
            end
            trip = (m_streak == LIM);
            case (m_mode)
               ModeOff:      m_mode = ModeDrive;
               ModeDrive:    if (trip) m_mode = ModeTripped;
                             else if (old_low) m_mode = ModeDriveLow;
               ModeDriveLow: if (trip) m_mode = ModeTripped;
                             else if (!old_low) m_mode = ModeDrive;
               ModeTripped: begin
                  m_cool = 0;
                  if (ifc.pwm_synch && !bad) m_mode = ModeCooling;
               end
               ModeCooling: begin
                  if (ifc.pwm_synch && bad) begin
                     m_mode = ModeTripped;
                     m_cool = 0;
                  end else if (m_cool == COOLN - 1 || ifc.clr_fault) begin
                     m_mode = old_low ? ModeDriveLow : ModeDrive;
                  end else begin
                     m_cool++;
                  end
               end
               default: m_mode = ModeOff;
            endcase
         end
      end
      mtr  = (m_mode == ModeDrive) || (m_mode == ModeDriveLow);
      shut = (m_mode == ModeTripped) || (m_mode == ModeCooling);
      exp_q.push_back({mtr, m_low, shut, shut, m_low});
   endtask

   always @(negedge clk) begin
      logic [4:0] e, g;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = {ifc.mtr_en, ifc.batt_low, ifc.OVR_I_shtdwn, ifc.fault_code};
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL outputs {mtr_en,batt_low,shtdwn,code}: got %b expected %b (cycle %0d)",
                     g, e, cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
   endtask

   task automatic pick_batt();
      case ($urandom_range(0, 3))
         0: ifc.batt = 12'($urandom_range(0, 4095));
         1: ifc.batt = 12'(int'(THR) - 1 + int'($urandom_range(0, 2)));
         2: ifc.batt = 12'(int'(THR) + int'(HYS) - 1 + int'($urandom_range(0, 2)));
         default: ifc.batt = 12'h850;
      endcase
   endtask

   task automatic step(input bit r, input bit l);
      ifc.pwm_synch  = (ph == 0);
      ifc.OVR_I_rght = r;
      ifc.OVR_I_lft  = l;
      if (rnd) begin
         if ($urandom_range(0, 19) == 0) begin
            ifc.batt_vld = 1'b1;
            pick_batt();
         end
         if ($urandom_range(0, 299) == 0) ifc.clr_fault = 1'b1;
         ifc.pwr_up = ($urandom_range(0, 799) != 0);
      end
      tick();
      ifc.batt_vld  = 1'b0;
      ifc.clr_fault = 1'b0;
      ph = (ph + 1) % PER;
   endtask

   // kind 0 clean, 1 held after the start clock, 2 pulses only inside blanking, 3 sparse.
   task automatic period(input int kind);
      bit r, l;
      for (int i = 0; i < PER; i++) begin
         r = 1'b0;
         l = 1'b0;
         case (kind)
            1: r = (i >= 1);
            2: r = (i >= 1 && i <= BLK) && ($urandom_range(0, 1) == 1);
            3: begin
               r = ($urandom_range(0, 15) == 0);
               l = ($urandom_range(0, 15) == 0);
            end
            default: ;
         endcase
         step(r, l);
      end
   endtask

   task automatic trip_and_cool();
      while (ph != 0) step(1'b0, 1'b0);
      repeat (LIM) period(1);
      check("pre_trip_shtdwn", ifc.OVR_I_shtdwn, 0);
      step(1'b0, 1'b0);
      check("trip_shtdwn", ifc.OVR_I_shtdwn, 1);
      check("trip_mtr_en", ifc.mtr_en, 0);
      while (ph != 0) step(1'b0, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic wait_mtr(input int bound, output int n);
      n = 0;
      while (!ifc.mtr_en && n < bound) begin
         step(1'b0, 1'b0);
         n++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      ifc.pwm_synch = 0; ifc.OVR_I_lft = 0; ifc.OVR_I_rght = 0; ifc.batt = 12'hFFF;
      ifc.batt_vld = 0; ifc.pwr_up = 0; ifc.clr_fault = 0;
      repeat (3) tick();
      rst = 1'b0;
      check("reset_mtr_en", ifc.mtr_en, 0);
      check("reset_fault_code", ifc.fault_code, 0);

      ifc.pwr_up = 1'b1;
      tick();
      check("pwrup_mtr_en", ifc.mtr_en, 1);
      check("pwrup_fault_code", ifc.fault_code, 0);

      ph = 0;
      repeat (20) period(2);
      check("blanking_no_trip", ifc.OVR_I_shtdwn, 0);

      repeat (7) period(1);
      repeat (2) period(0);
      check("seven_periods_no_trip", ifc.OVR_I_shtdwn, 0);

      trip_and_cool();
      wait_mtr(1200, n);
      check("cool_duration", n, COOLN);

      trip_and_cool();
      repeat (3) period(0);
      period(1);
      step(1'b0, 1'b0);
      check("cool_refault_shtdwn", ifc.OVR_I_shtdwn, 1);
      while (ph != 0) step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      wait_mtr(1200, n);
      check("cool_restart_duration", n, COOLN);

      trip_and_cool();
      repeat (50) step(1'b0, 1'b0);
      ifc.clr_fault = 1'b1;
      step(1'b0, 1'b0);
      check("clr_fault_mtr_en", ifc.mtr_en, 1);
      check("clr_fault_shtdwn", ifc.OVR_I_shtdwn, 0);

      ifc.batt = 12'h350; ifc.batt_vld = 1'b1; step(1'b0, 1'b0);
      check("batt_350_low", ifc.batt_low, 1);
      repeat (2) step(1'b0, 1'b0);
      check("warn_mtr_en", ifc.mtr_en, 1);
      ifc.batt = 12'h850; ifc.batt_vld = 1'b1; step(1'b0, 1'b0);
      check("batt_850_hold", ifc.batt_low, 1);
      ifc.batt = 12'h87F; ifc.batt_vld = 1'b1; step(1'b0, 1'b0);
      check("batt_87f_hold", ifc.batt_low, 1);
      ifc.batt = 12'h880; ifc.batt_vld = 1'b1; step(1'b0, 1'b0);
      check("batt_880_clear", ifc.batt_low, 0);
      ifc.batt = 12'h800; ifc.batt_vld = 1'b1; step(1'b0, 1'b0);
      check("batt_800_hold", ifc.batt_low, 0);
      ifc.batt = 12'h7FF; ifc.batt_vld = 1'b1; step(1'b0, 1'b0);
      check("batt_7ff_set", ifc.batt_low, 1);
      ifc.batt = 12'h900; ifc.batt_vld = 1'b1; step(1'b0, 1'b0);
      check("batt_900_clear", ifc.batt_low, 0);
      step(1'b0, 1'b0);
      check("run_mtr_en", ifc.mtr_en, 1);

      while (ph != 0) step(1'b0, 1'b0);
      ifc.batt = 12'h350; ifc.batt_vld = 1'b1;
      trip_and_cool();
      check("both_fault_code", ifc.fault_code, 3);
      check("both_mtr_en", ifc.mtr_en, 0);
      ifc.batt = 12'h900; ifc.batt_vld = 1'b1;
      wait_mtr(1500, n);
      check("both_cleared_code", ifc.fault_code, 0);
      check("both_cleared_mtr_en", ifc.mtr_en, 1);

      trip_and_cool();
      repeat (100) step(1'b0, 1'b0);
      rst = 1'b1; step(1'b0, 1'b0); rst = 1'b0;
      check("midcool_rst_mtr_en", ifc.mtr_en, 0);
      check("midcool_rst_shtdwn", ifc.OVR_I_shtdwn, 0);
      check("midcool_rst_code", ifc.fault_code, 0);
      step(1'b0, 1'b0);
      check("post_rst_mtr_en", ifc.mtr_en, 1);

      trip_and_cool();
      repeat (10) step(1'b0, 1'b0);
      ifc.pwr_up = 1'b0; step(1'b0, 1'b0);
      check("pwr_down_shtdwn", ifc.OVR_I_shtdwn, 0);
      check("pwr_down_mtr_en", ifc.mtr_en, 0);
      ifc.pwr_up = 1'b1; step(1'b0, 1'b0);
      check("pwr_back_mtr_en", ifc.mtr_en, 1);

      rnd = 1'b1;
      repeat (80) period(int'($urandom_range(0, 3)));
      rnd = 1'b0;
      ifc.pwr_up = 1'b1;
      repeat (4) step(1'b0, 1'b0);

      @(negedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fault_supervisor.md
Name: fault_supervisor

Overview:
- Central fault sequencer for the Segway motor path.
- Qualifies raw over-current flags from the left/right motor drivers against PWM blanking, and debounces battery A2D readings into a hysteretic low-battery flag.
- Runs the shutdown/cool-down/recovery state machine that gates motor enable and reports fault status to the piezo/auth logic.
- Sits between the A2D/PWM blocks and the motor-drive enable.

Parameters:
- OVR_I_LIMIT, 8: consecutive faulted PWM periods before over-current shutdown (range 1..255).
- BLANK, 40: clocks after each pwm_synch during which OVR_I inputs are ignored.
- COOL_CYCLES, 1000000: clean clocks required in COOL before recovery (24-bit counter).
- BATT_THRESH, 12'h800: batt below this sets batt_low.
- BATT_HYST, 12'h080: batt must reach BATT_THRESH+BATT_HYST to clear batt_low.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pwm_synch  in  1  one-clock pulse at start of each PWM period
- OVR_I_lft  in  1  raw left driver over-current flag
- OVR_I_rght  in  1  raw right driver over-current flag
- batt  in  12  battery A2D reading
- batt_vld  in  1  one-clock strobe, batt is valid
- pwr_up  in  1  rider authorised / system powered
- clr_fault  in  1  one-clock request to abort COOL immediately (service use)
- mtr_en  out  1  motor drive enable
- batt_low  out  1  qualified low-battery flag
- OVR_I_shtdwn  out  1  over-current shutdown active
- fault_code  out  2  00 none, 01 batt_low, 10 over-current, 11 both

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state=IDLE; mtr_en=0, batt_low=0, OVR_I_shtdwn=0, fault_code=00.
  - All counters and the period flag cleared.
  - Reset mid-operation aborts any shutdown or cool-down in the next cycle.
- Blanking:
  - blank_cnt loads 0 on pwm_synch and increments, saturating at BLANK.
  - Sampling window is active while blank_cnt==BLANK.
  - per_flag sets if (OVR_I_lft|OVR_I_rght) is high in the window.
- Period accounting at each pwm_synch:
  - If per_flag=1: oc_cnt increments, saturating at OVR_I_LIMIT.
  - Otherwise oc_cnt clears.
  - per_flag clears in the same cycle. An OVR_I sample coinciding with pwm_synch belongs to the ending period.
- oc_trip: combinational, oc_cnt==OVR_I_LIMIT.
- Battery qualification:
  - Evaluated only on batt_vld; batt_low holds between strobes.
  - batt_low sets if batt < BATT_THRESH.
  - batt_low clears if batt >= BATT_THRESH+BATT_HYST; values in between hold.
  - The sum is computed at 13 bits, no wrap.
  - batt_low operates in all states except under reset.
- FSM (registered outputs, update the cycle after the causing condition):
  - IDLE: mtr_en=0. Goes to RUN when pwr_up=1.
  - RUN: mtr_en=1. Goes to SHTDWN on oc_trip. Goes to WARN when batt_low=1.
  - WARN: mtr_en=1. Goes to SHTDWN on oc_trip. Returns to RUN when batt_low=0.
  - SHTDWN: mtr_en=0, OVR_I_shtdwn=1. cool_cnt cleared. Goes to COOL at the next pwm_synch with per_flag=0.
  - COOL: mtr_en=0, OVR_I_shtdwn=1.
    - cool_cnt increments every clock.
    - Any period ending with per_flag=1 returns to SHTDWN.
    - cool_cnt==COOL_CYCLES-1 or clr_fault goes to RUN (or WARN if batt_low), with OVR_I_shtdwn=0 next cycle.
  - pwr_up=0 in any state returns to IDLE next cycle. OVR_I_shtdwn clears and counters are cleared, except batt_low, which keeps its value.
- Priority: over-current beats battery; oc_trip in WARN goes to SHTDWN. fault_code reflects both flags simultaneously.
- fault_code: {OVR_I_shtdwn, batt_low}, registered.
- Latency: OVR_I asserted continuously from a period start produces OVR_I_shtdwn=1 and mtr_en=0 one clock after the OVR_I_LIMIT-th pwm_synch.

Test Plan:
- Reset then pwr_up=1: one cycle later mtr_en=1, fault_code=00. Assert rst for one cycle mid-COOL: next cycle all outputs 0, state IDLE.
- Blanking (OVR_I_LIMIT=8, BLANK=40): OVR_I_rght pulses only in clocks 0..39 after each pwm_synch for 20 periods -> OVR_I_shtdwn stays 0.
- OVR_I_rght=1 held for 8 PWM periods -> OVR_I_shtdwn=1, mtr_en=0 exactly one clock after the 8th pwm_synch. With 7 faulted periods followed by one clean period, oc_cnt clears and there is no trip.
- Recovery (COOL_CYCLES=1000): clear OVR_I -> COOL, then mtr_en=1 after 1000 clocks. Re-assert OVR_I for one period during COOL -> back to SHTDWN, timer restarts. clr_fault in COOL -> RUN next cycle.
- Battery hysteresis: batt_vld with batt=12'h350 -> batt_low=1, state WARN, mtr_en=1. batt=12'h850 -> remains 1. batt=12'h900 -> clears, state RUN.
- Simultaneous faults: batt=12'h350 and OVR_I_rght=1 from the same cycle -> fault_code=11, mtr_en=0. Clear both (batt=12'h900) -> after COOL, fault_code=00 and mtr_en=1.
